// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the LCD delay timer.
// Channel state encoding plus LCD sequencing waits in 1 us ticks.
package delay_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // LCD waits expressed in timebase ticks (1 us each at 27 MHz / 27)
    localparam int unsigned LCD_PWR_ON_TICKS = 15000;
    localparam int unsigned LCD_CLEAR_TICKS  = 1640;
    localparam int unsigned LCD_CMD_TICKS    = 40;

    // Width of a counter holding 0..n-1; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_timer_ch.sv
// One delay channel: IDLE/RUN FSM with tick counter and reload.
// done and busy are registered; abort beats expiry beats start.
module delay_timer_ch #(
    parameter int unsigned CTR_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 periodic,
    input  logic                 abort,
    input  logic [CTR_WIDTH-1:0] load,
    output logic                 busy,
    output logic                 done
);
    import delay_timer_pkg::*;

    localparam logic [CTR_WIDTH-1:0] ONE = CTR_WIDTH'(1);

    ch_state_e            state_q;
    logic [CTR_WIDTH-1:0] ctr_q;
    logic [CTR_WIDTH-1:0] reload_q;
    logic                 mode_q;
    logic                 busy_q;
    logic                 done_q;

    // Channel FSM: load on start, count ticks, pulse done at expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                ctr_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (load == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                ctr_q    <= load;
                                reload_q <= load;
                                mode_q   <= periodic;
                                state_q  <= ST_RUN;
                                busy_q   <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            if (ctr_q == ONE) begin
                                done_q <= 1'b1;
                                if (mode_q) begin
                                    ctr_q <= reload_q;
                                end else begin
                                    ctr_q   <= '0;
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                ctr_q <= ctr_q - ONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/delay_timer.sv
// Multi-channel delay timer: shared prescaler tick feeding
// NUM_CH independent one-shot/periodic channels.
module delay_timer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CTR_WIDTH = 20,
    parameter int unsigned PRESCALE  = 27
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             start,
    input  logic [NUM_CH-1:0]             periodic,
    input  logic [NUM_CH-1:0]             abort,
    input  logic [NUM_CH*CTR_WIDTH-1:0]   load,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             done,
    output logic                          tick
);
    import delay_timer_pkg::*;

    localparam int unsigned    PW      = cnt_width(PRESCALE);
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_q;
    logic [PW-1:0] ps_d;
    logic          tick_q;
    logic          tick_d;

    // Next prescaler count and terminal detect
    always_comb begin
        tick_d = (ps_q == PS_LAST);
        ps_d   = tick_d ? '0 : ps_q + 1'b1;
    end

    // Free-running prescaler; tick is registered so it is glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        delay_timer_ch #(
            .CTR_WIDTH (CTR_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick_q),
            .start    (start[i]),
            .periodic (periodic[i]),
            .abort    (abort[i]),
            .load     (load[i*CTR_WIDTH +: CTR_WIDTH]),
            .busy     (busy[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer: stimulus pushes expected
// done cycles, a negedge monitor pops and compares them.
module tb_delay_timer;

    localparam int W = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [1:0]     start = '0;
    logic [1:0]     periodic = '0;
    logic [1:0]     abort = '0;
    logic [2*W-1:0] load = '0;
    logic [1:0]     busy;
    logic [1:0]     done;
    logic           tick;

    logic [0:0]     start4 = '0;
    logic [0:0]     periodic4 = '0;
    logic [0:0]     abort4 = '0;
    logic [W-1:0]   load4 = '0;
    logic [0:0]     busy4;
    logic [0:0]     done4;
    logic           tick4;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];
    int lo4[$];
    int hi4[$];
    int e0, e1, el, eh;

    delay_timer #(.NUM_CH(2), .CTR_WIDTH(W), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .periodic(periodic),
        .abort(abort), .load(load), .busy(busy), .done(done), .tick(tick)
    );

    delay_timer #(.NUM_CH(1), .CTR_WIDTH(W), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .periodic(periodic4),
        .abort(abort4), .load(load4), .busy(busy4), .done(done4), .tick(tick4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic go(input int ch, input int l, input logic per);
        load[ch*W +: W] = W'(l);
        periodic[ch]    = per;
        start[ch]       = 1'b1;
    endtask

    task automatic rel();
        @(negedge clk);
        start = '0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: match every done pulse against the expected queues
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0] < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL done0_missed: got none, required at cyc %0d", q0[0]);
            void'(q0.pop_front());
        end
        if (done[0]) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL done0_extra: got done at cyc %0d, required none", cyc);
            end else begin
                e0 = q0.pop_front();
                if (e0 != cyc) begin
                    n_fail++;
                    $display("FAIL done0_time: got cyc %0d required cyc %0d", cyc, e0);
                end
            end
        end
        if (q1.size() > 0 && q1[0] < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL done1_missed: got none, required at cyc %0d", q1[0]);
            void'(q1.pop_front());
        end
        if (done[1]) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL done1_extra: got done at cyc %0d, required none", cyc);
            end else begin
                e1 = q1.pop_front();
                if (e1 != cyc) begin
                    n_fail++;
                    $display("FAIL done1_time: got cyc %0d required cyc %0d", cyc, e1);
                end
            end
        end
        if (hi4.size() > 0 && hi4[0] < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL done4_missed: got none, required by cyc %0d", hi4[0]);
            void'(lo4.pop_front());
            void'(hi4.pop_front());
        end
        if (done4[0]) begin
            n_chk++;
            if (hi4.size() == 0) begin
                n_fail++;
                $display("FAIL done4_extra: got done at cyc %0d, required none", cyc);
            end else begin
                el = lo4.pop_front();
                eh = hi4.pop_front();
                if (cyc < el || cyc > eh) begin
                    n_fail++;
                    $display("FAIL done4_time: got cyc %0d required %0d..%0d", cyc, el, eh);
                end
            end
        end
    end

    initial begin
        int s;
        int s2;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", tick, 0);
        chk("rst_tick4", tick4, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("tick_p1_high", tick, 1);
        repeat (2) @(negedge clk);

        // One-shot load 5, prescale 1
        s = cyc + 1;
        go(0, 5, 1'b0);
        q0.push_back(s + 5);
        rel();
        for (int k = 0; k <= 5; k++) begin
            chk("t1_busy0", busy[0], (k < 5) ? 1 : 0);
            @(negedge clk);
        end
        wait_cyc(s + 12);
        chk("t1_idle", busy[0], 0);

        // Prescale 4: tick period and windowed expiry
        n = 0;
        while (!tick4 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("tick4_found", tick4, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("tick4_period", tick4, (k == 4) ? 1 : 0);
        end
        @(negedge clk);
        s = cyc + 1;
        load4 = W'(3);
        start4 = 1'b1;
        lo4.push_back(s + 9);
        hi4.push_back(s + 12);
        @(negedge clk);
        start4 = '0;
        chk("t2_busy4", busy4, 1);
        wait_cyc(s + 14);
        chk("t2_idle4", busy4, 0);

        // Periodic load 4, load change mid-run, then abort
        s = cyc + 1;
        go(1, 4, 1'b1);
        q1.push_back(s + 4);
        q1.push_back(s + 8);
        q1.push_back(s + 12);
        rel();
        wait_cyc(s + 2);
        load[W +: W] = W'(7);
        periodic[1] = 1'b0;
        wait_cyc(s + 13);
        chk("t3_busy_run", busy[1], 1);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        chk("t3_abort_busy", busy[1], 0);
        wait_cyc(s + 22);
        chk("t3_stays_idle", busy[1], 0);

        // Zero load: one-shot and periodic give a single done
        s = cyc + 1;
        go(0, 0, 1'b0);
        go(1, 0, 1'b1);
        q0.push_back(s);
        q1.push_back(s);
        rel();
        chk("t4_busy_a", busy, 0);
        @(negedge clk);
        chk("t4_busy_b", busy, 0);
        repeat (5) @(negedge clk);

        // Abort on terminal tick suppresses done
        s = cyc + 1;
        go(0, 3, 1'b0);
        rel();
        wait_cyc(s + 2);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("t5_abort_busy", busy[0], 0);
        repeat (4) @(negedge clk);

        // Start while busy is ignored; restart while done high
        s = cyc + 1;
        go(0, 6, 1'b0);
        q0.push_back(s + 6);
        rel();
        wait_cyc(s + 2);
        go(0, 2, 1'b1);
        rel();
        wait_cyc(s + 5);
        chk("t5_busy_keep", busy[0], 1);
        wait_cyc(s + 6);
        chk("t5_busy_fall", busy[0], 0);
        s2 = cyc + 1;
        go(0, 2, 1'b0);
        q0.push_back(s2 + 2);
        rel();
        wait_cyc(s2 + 4);
        chk("t5_restart_idle", busy[0], 0);

        // Reset mid-count
        s = cyc + 1;
        go(0, 5, 1'b0);
        rel();
        wait_cyc(s + 2);
        chk("t6_pre_busy", busy[0], 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_tick", tick, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_post_busy", busy, 0);

        // Both channels in the same cycle
        s = cyc + 1;
        go(0, 2, 1'b0);
        go(1, 6, 1'b0);
        q0.push_back(s + 2);
        q1.push_back(s + 6);
        rel();
        chk("t6_both_busy", busy, 3);
        wait_cyc(s + 3);
        chk("t6_ch0_done_busy", busy, 2);
        wait_cyc(s + 9);
        chk("t6_both_idle", busy, 0);

        repeat (4) @(negedge clk);
        while (q0.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL done0_left: got none, required at cyc %0d", q0.pop_front());
        end
        while (q1.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL done1_left: got none, required at cyc %0d", q1.pop_front());
        end
        while (hi4.size() > 0) begin
            n_chk++; n_fail++;
            void'(lo4.pop_front());
            $display("FAIL done4_left: got none, required by cyc %0d", hi4.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
